// File: rtl/reorder_buffer.sv
// reorder_buffer: circular, dual-width, in-order reorder buffer between
// rename/dispatch and retirement.
//  - Accepts up to two (T, T_old) pairs per cycle at the tail.
//  - Marks entries complete from two CDB tags.
//  - Retires up to two completed head entries per cycle. The retire outputs
//    are registered.
//  - On a branch mispredict, every entry younger than the head is squashed.
// ROB_full_o encoding: 2'd0 = NOT_FULL, 2'd1 = ONE_LEFT, 2'd2 = FULL.
// Optional feature macro: ROB_DEBUG_EN. It adds the head_debug and
// tail_debug pointer outputs.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif

module reorder_buffer #(
    parameter int ROB_SIZE    = `ROB_SIZE,
    parameter int PREG_NUMBER = `PREG_NUMBER,
    localparam int PW = $clog2(ROB_SIZE),
    localparam int TW = $clog2(PREG_NUMBER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dispatch_en_i,
    input  logic          dispatch_size_i,
    input  logic [TW-1:0] preg_tag_old_i [2],
    input  logic [TW-1:0] freeReg_i [2],
    input  logic [TW-1:0] CDB_i [2],
    input  logic          branch_mispredicted_i,
    output logic [TW-1:0] T_o [2],
    output logic [TW-1:0] T_old_o [2],
    output logic          retire_en_o [2],
    output logic [1:0]    ROB_full_o
`ifdef ROB_DEBUG_EN
    ,
    output logic [PW-1:0] head_debug,
    output logic [PW-1:0] tail_debug
`endif
);

    localparam int CW = PW + 1;
    localparam logic [1:0] ST_NOT_FULL = 2'd0;
    localparam logic [1:0] ST_ONE_LEFT = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;

    // Entry storage. The tag compare against the CDB needs every T at once,
    // so the storage is built from registers.
    logic [TW-1:0]       t_mem_q    [ROB_SIZE];
    logic [TW-1:0]       t_mem_d    [ROB_SIZE];
    logic [TW-1:0]       told_mem_q [ROB_SIZE];
    logic [TW-1:0]       told_mem_d [ROB_SIZE];
    logic [ROB_SIZE-1:0] complete_q, complete_d;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          retire_en_q [2];
    logic          retire_en_d [2];
    logic [TW-1:0] t_out_q    [2];
    logic [TW-1:0] t_out_d    [2];
    logic [TW-1:0] told_out_q [2];
    logic [TW-1:0] told_out_d [2];

    logic [ROB_SIZE-1:0] valid;
    logic [ROB_SIZE-1:0] cdb_hit;

    logic          is_full, is_one_left;
    logic          acc0, acc1, ret0, ret1;
    logic [PW-1:0] head_p1, tail_p1;
    logic [CW-1:0] n_acc, n_ret;

    // Per-entry occupancy and CDB match. Only entries between head and tail
    // before the edge can match, so same-cycle dispatches are never matched.
    for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
        logic [PW-1:0] offset;
        assign offset       = PW'(gi) - head_q;
        assign valid[gi]    = {1'b0, offset} < count_q;
        assign cdb_hit[gi]  = valid[gi] &&
                              ((t_mem_q[gi] == CDB_i[0]) || (t_mem_q[gi] == CDB_i[1]));
    end

    // Occupancy status, dispatch acceptance and in-order retire selection.
    always_comb begin
        is_full     = (count_q == CW'(ROB_SIZE));
        is_one_left = (count_q == CW'(ROB_SIZE - 1));
        ROB_full_o  = is_full ? ST_FULL : (is_one_left ? ST_ONE_LEFT : ST_NOT_FULL);

        head_p1 = head_q + PW'(1);
        tail_p1 = tail_q + PW'(1);

        acc0 = dispatch_en_i && !branch_mispredicted_i && !is_full;
        acc1 = acc0 && dispatch_size_i && !is_one_left;

        // Completion for retire includes a same-cycle CDB hit (bypass).
        ret0 = !branch_mispredicted_i && (count_q != '0) &&
               (complete_q[head_q] || cdb_hit[head_q]);
        ret1 = ret0 && (count_q >= CW'(2)) &&
               (complete_q[head_p1] || cdb_hit[head_p1]);

        n_acc = CW'(acc0) + CW'(acc1);
        n_ret = CW'(ret0) + CW'(ret1);
    end

    // Next-state for entries, pointers, occupancy and the retire outputs.
    always_comb begin
        t_mem_d    = t_mem_q;
        told_mem_d = told_mem_q;
        complete_d = complete_q | cdb_hit;

        if (acc0) begin
            t_mem_d[tail_q]    = freeReg_i[0];
            told_mem_d[tail_q] = preg_tag_old_i[0];
            complete_d[tail_q] = 1'b0;
        end
        if (acc1) begin
            t_mem_d[tail_p1]    = freeReg_i[1];
            told_mem_d[tail_p1] = preg_tag_old_i[1];
            complete_d[tail_p1] = 1'b0;
        end

        if (branch_mispredicted_i) begin
            // Keep only the head entry; CDB hits on it were applied above.
            head_d = head_q;
            if (count_q != '0) begin
                tail_d  = head_p1;
                count_d = CW'(1);
            end else begin
                tail_d  = head_q;
                count_d = '0;
            end
        end else begin
            head_d  = head_q + PW'(n_ret);
            tail_d  = tail_q + PW'(n_acc);
            count_d = count_q + n_acc - n_ret;
        end

        retire_en_d[0] = ret0;
        retire_en_d[1] = ret1;
        t_out_d[0]     = ret0 ? t_mem_q[head_q]     : t_out_q[0];
        told_out_d[0]  = ret0 ? told_mem_q[head_q]  : told_out_q[0];
        t_out_d[1]     = ret1 ? t_mem_q[head_p1]    : t_out_q[1];
        told_out_d[1]  = ret1 ? told_mem_q[head_p1] : told_out_q[1];
    end

    // Tag payload storage. Contents past tail are never observed, so it has no reset.
    always_ff @(posedge clk) begin
        t_mem_q    <= t_mem_d;
        told_mem_q <= told_mem_d;
    end

    // Control state and registered retire outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            complete_q  <= '0;
            retire_en_q <= '{1'b0, 1'b0};
            t_out_q     <= '{'0, '0};
            told_out_q  <= '{'0, '0};
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            complete_q  <= complete_d;
            retire_en_q <= retire_en_d;
            t_out_q     <= t_out_d;
            told_out_q  <= told_out_d;
        end
    end

    assign retire_en_o = retire_en_q;
    assign T_o         = t_out_q;
    assign T_old_o     = told_out_q;

`ifdef ROB_DEBUG_EN
    assign head_debug = head_q;
    assign tail_debug = tail_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatch, CDB completion with bypass,
// single and dual retire, full and one-left limits, mispredict, and reset.
module tb_reorder_buffer;

    localparam int TW = 6;
    localparam int PW = 5;
    localparam logic [1:0] NOT_FULL = 2'd0;
    localparam logic [1:0] ONE_LEFT = 2'd1;
    localparam logic [1:0] FULLST   = 2'd2;
    localparam logic [TW-1:0] IDLE_TAG = 6'h3F;

    logic          clk = 1'b0;
    logic          reset;
    logic          dispatch_en_i;
    logic          dispatch_size_i;
    logic [TW-1:0] preg_tag_old_i [2];
    logic [TW-1:0] freeReg_i [2];
    logic [TW-1:0] CDB_i [2];
    logic          branch_mispredicted_i;
    logic [TW-1:0] T_o [2];
    logic [TW-1:0] T_old_o [2];
    logic          retire_en_o [2];
    logic [1:0]    ROB_full_o;
`ifdef ROB_DEBUG_EN
    logic [PW-1:0] head_debug, tail_debug;
`endif

    int errors = 0;
    int checks = 0;

    reorder_buffer #(.ROB_SIZE(32), .PREG_NUMBER(64)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .dispatch_en_i         (dispatch_en_i),
        .dispatch_size_i       (dispatch_size_i),
        .preg_tag_old_i        (preg_tag_old_i),
        .freeReg_i             (freeReg_i),
        .CDB_i                 (CDB_i),
        .branch_mispredicted_i (branch_mispredicted_i),
        .T_o                   (T_o),
        .T_old_o               (T_old_o),
        .retire_en_o           (retire_en_o),
        .ROB_full_o            (ROB_full_o)
`ifdef ROB_DEBUG_EN
        ,
        .head_debug            (head_debug),
        .tail_debug            (tail_debug)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        dispatch_en_i         = 1'b0;
        dispatch_size_i       = 1'b0;
        freeReg_i[0]          = '0;
        freeReg_i[1]          = '0;
        preg_tag_old_i[0]     = '0;
        preg_tag_old_i[1]     = '0;
        CDB_i[0]              = IDLE_TAG;
        CDB_i[1]              = IDLE_TAG;
        branch_mispredicted_i = 1'b0;
    endtask

    task automatic disp(input logic sz, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                        input logic [TW-1:0] o0, input logic [TW-1:0] o1);
        dispatch_en_i     = 1'b1;
        dispatch_size_i   = sz;
        freeReg_i[0]      = t0;
        freeReg_i[1]      = t1;
        preg_tag_old_i[0] = o0;
        preg_tag_old_i[1] = o1;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [TW-1:0] ta, tb2;
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ret0", 32'(retire_en_o[0]), 0);
        chk("rst_ret1", 32'(retire_en_o[1]), 0);
        chk("rst_T0", 32'(T_o[0]), 0);
        chk("rst_Told1", 32'(T_old_o[1]), 0);
        chk("rst_full", 32'(ROB_full_o), 32'(NOT_FULL));
`ifdef ROB_DEBUG_EN
        chk("rst_head", 32'(head_debug), 0);
        chk("rst_tail", 32'(tail_debug), 0);
`endif
        reset = 1'b0;

        // 1: dual dispatch, then retire head via CDB bypass
        disp(1'b1, 6'h32, 6'h33, 6'd1, 6'd2);
        tick();
        set_idle();
        chk("t1_disp_ret0", 32'(retire_en_o[0]), 0);
`ifdef ROB_DEBUG_EN
        chk("t1_head", 32'(head_debug), 0);
        chk("t1_tail", 32'(tail_debug), 2);
`endif
        CDB_i[0] = 6'h32;
        tick();
        set_idle();
        chk("t1_ret0", 32'(retire_en_o[0]), 1);
        chk("t1_ret1", 32'(retire_en_o[1]), 0);
        chk("t1_T0", 32'(T_o[0]), 32'h32);
        chk("t1_Told0", 32'(T_old_o[0]), 1);
`ifdef ROB_DEBUG_EN
        chk("t1_head_after", 32'(head_debug), 1);
`endif
        tick();
        chk("t1_ret0_drop", 32'(retire_en_o[0]), 0);
        chk("t1_T0_hold", 32'(T_o[0]), 32'h32);

        // 2: two more dual dispatches, then dual retire
        disp(1'b1, 6'h34, 6'h35, 6'd3, 6'd4);
        tick();
        disp(1'b1, 6'h36, 6'h37, 6'd5, 6'd6);
        tick();
        set_idle();
`ifdef ROB_DEBUG_EN
        chk("t2_tail", 32'(tail_debug), 6);
`endif
        CDB_i[0] = 6'h33;
        CDB_i[1] = 6'h34;
        tick();
        set_idle();
        chk("t2_ret0", 32'(retire_en_o[0]), 1);
        chk("t2_ret1", 32'(retire_en_o[1]), 1);
        chk("t2_T0", 32'(T_o[0]), 32'h33);
        chk("t2_T1", 32'(T_o[1]), 32'h34);
        chk("t2_Told0", 32'(T_old_o[0]), 2);
        chk("t2_Told1", 32'(T_old_o[1]), 3);
`ifdef ROB_DEBUG_EN
        chk("t2_head", 32'(head_debug), 3);
`endif
        tick();
        chk("t2_ret0_drop", 32'(retire_en_o[0]), 0);
        chk("t2_ret1_drop", 32'(retire_en_o[1]), 0);

        // 3: younger entries complete first; the head blocks retirement
        CDB_i[0] = 6'h36;
        CDB_i[1] = 6'h37;
        tick();
        set_idle();
        chk("t3_blocked_ret0", 32'(retire_en_o[0]), 0);
        chk("t3_blocked_ret1", 32'(retire_en_o[1]), 0);
        CDB_i[0] = 6'h35;
        tick();
        set_idle();
        chk("t3_ret0", 32'(retire_en_o[0]), 1);
        chk("t3_ret1", 32'(retire_en_o[1]), 1);
        chk("t3_T0", 32'(T_o[0]), 32'h35);
        chk("t3_T1", 32'(T_o[1]), 32'h36);
        chk("t3_Told0", 32'(T_old_o[0]), 4);
        chk("t3_Told1", 32'(T_old_o[1]), 5);
`ifdef ROB_DEBUG_EN
        chk("t3_head", 32'(head_debug), 5);
`endif
        tick();
        chk("t3_last_ret0", 32'(retire_en_o[0]), 1);
        chk("t3_last_ret1", 32'(retire_en_o[1]), 0);
        chk("t3_last_T0", 32'(T_o[0]), 32'h37);
        chk("t3_last_Told0", 32'(T_old_o[0]), 6);
        chk("t3_T1_hold", 32'(T_o[1]), 32'h36);
`ifdef ROB_DEBUG_EN
        chk("t3_head_end", 32'(head_debug), 6);
        chk("t3_tail_end", 32'(tail_debug), 6);
`endif
        tick();
        chk("t3_idle_ret0", 32'(retire_en_o[0]), 0);
        chk("t3_empty_full", 32'(ROB_full_o), 32'(NOT_FULL));

        // 4: fill to FULL (tag j at position j), then drain two per cycle
        disp(1'b0, 6'd0, 6'd0, 6'h20, 6'd0);
        tick();
        for (int k = 1; k <= 15; k++) begin
            chk("t4_fill_notfull", 32'(ROB_full_o), 32'(NOT_FULL));
            ta  = 6'(2 * k - 1);
            tb2 = 6'(2 * k);
            disp(1'b1, ta, tb2, ta ^ 6'h20, tb2 ^ 6'h20);
            tick();
        end
        set_idle();
        chk("t4_one_left", 32'(ROB_full_o), 32'(ONE_LEFT));
        disp(1'b1, 6'd31, 6'd40, 6'd31 ^ 6'h20, 6'd0);
        tick();
        set_idle();
        chk("t4_full", 32'(ROB_full_o), 32'(FULLST));
`ifdef ROB_DEBUG_EN
        chk("t4_full_head", 32'(head_debug), 6);
        chk("t4_full_tail", 32'(tail_debug), 6);
`endif
        disp(1'b1, 6'd41, 6'd42, 6'd0, 6'd0);
        tick();
        set_idle();
        chk("t4_full_ignored", 32'(ROB_full_o), 32'(FULLST));
        chk("t4_full_noret", 32'(retire_en_o[0]), 0);
`ifdef ROB_DEBUG_EN
        chk("t4_ignored_tail", 32'(tail_debug), 6);
`endif
        for (int i = 0; i < 16; i++) begin
            ta  = 6'(2 * i);
            tb2 = 6'(2 * i + 1);
            CDB_i[0] = ta;
            CDB_i[1] = tb2;
            tick();
            chk("t4_drain_ret0", 32'(retire_en_o[0]), 1);
            chk("t4_drain_ret1", 32'(retire_en_o[1]), 1);
            chk("t4_drain_T0", 32'(T_o[0]), 32'(ta));
            chk("t4_drain_T1", 32'(T_o[1]), 32'(tb2));
            chk("t4_drain_Told1", 32'(T_old_o[1]), 32'(tb2 ^ 6'h20));
            chk("t4_drain_full", 32'(ROB_full_o), 32'(NOT_FULL));
`ifdef ROB_DEBUG_EN
            chk("t4_drain_head", 32'(head_debug), 32'((8 + 2 * i) % 32));
`endif
        end
        set_idle();
        tick();
        chk("t4_empty_ret0", 32'(retire_en_o[0]), 0);
`ifdef ROB_DEBUG_EN
        chk("t4_empty_tail", 32'(tail_debug), 6);
`endif

        // 5: four singles, then mispredict with dispatch and a head CDB hit
        for (int j = 0; j < 4; j++) begin
            disp(1'b0, 6'(6'h10 + j), 6'd0, 6'(1 + j), 6'd0);
            tick();
        end
        set_idle();
`ifdef ROB_DEBUG_EN
        chk("t5_tail_pre", 32'(tail_debug), 10);
`endif
        disp(1'b1, 6'h14, 6'h15, 6'd7, 6'd8);
        branch_mispredicted_i = 1'b1;
        CDB_i[0] = 6'h10;
        tick();
        set_idle();
        chk("t5_mp_ret0", 32'(retire_en_o[0]), 0);
        chk("t5_mp_ret1", 32'(retire_en_o[1]), 0);
        chk("t5_mp_full", 32'(ROB_full_o), 32'(NOT_FULL));
`ifdef ROB_DEBUG_EN
        chk("t5_mp_head", 32'(head_debug), 6);
        chk("t5_mp_tail", 32'(tail_debug), 7);
`endif
        CDB_i[1] = 6'h11;
        tick();
        set_idle();
        chk("t5_keep_ret0", 32'(retire_en_o[0]), 1);
        chk("t5_squash_ret1", 32'(retire_en_o[1]), 0);
        chk("t5_keep_T0", 32'(T_o[0]), 32'h10);
        chk("t5_keep_Told0", 32'(T_old_o[0]), 1);
`ifdef ROB_DEBUG_EN
        chk("t5_head_end", 32'(head_debug), 7);
        chk("t5_tail_end", 32'(tail_debug), 7);
`endif

        // 6: reset with valid entries discards them
        disp(1'b1, 6'h16, 6'h17, 6'd9, 6'd10);
        tick();
        set_idle();
        reset = 1'b1;
        disp(1'b1, 6'h18, 6'h19, 6'd0, 6'd0);
        CDB_i[0] = 6'h16;
        tick();
        reset = 1'b0;
        set_idle();
        chk("t6_ret0", 32'(retire_en_o[0]), 0);
        chk("t6_ret1", 32'(retire_en_o[1]), 0);
        chk("t6_T0", 32'(T_o[0]), 0);
        chk("t6_Told0", 32'(T_old_o[0]), 0);
        chk("t6_full", 32'(ROB_full_o), 32'(NOT_FULL));
`ifdef ROB_DEBUG_EN
        chk("t6_head", 32'(head_debug), 0);
        chk("t6_tail", 32'(tail_debug), 0);
`endif
        CDB_i[0] = 6'h16;
        CDB_i[1] = 6'h17;
        tick();
        set_idle();
        chk("t6_discarded_ret0", 32'(retire_en_o[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
